// File: rtl/cvtb_mode_ctrl.sv
// Buffer ownership scheduler for the convertible FIFO/packet buffer:
// receive a packet, hand it to the processor, then drain it downstream.
module cvtb_mode_ctrl #(
   parameter int ADDR_W       = 8,
   parameter int PROC_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_eop,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              cpu_run,
   output logic              cpu_pc_reset,
   input  logic              cpu_done,
   output logic [ADDR_W-1:0] head_addr,
   output logic [ADDR_W-1:0] tail_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              out_valid,
   output logic              out_eop,
   input  logic              out_ready,
   output logic [1:0]        mem_owner,
   output logic              overflow,
   output logic              timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RECV = 2'b01,
      PROC = 2'b10,
      SEND = 2'b11
   } state_t;

   localparam logic [15:0]       WD_LAST  = 16'(PROC_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t      state;
   logic [15:0] wdog;
   logic        last_word;

   assign in_ready  = (state == IDLE) || (state == RECV);
   assign wr_en     = in_valid & in_ready;
   assign out_eop   = out_valid & (rd_addr == tail_addr);
   assign mem_owner = state;
   // The word at the top address closes the packet even without in_eop.
   assign last_word = in_eop || (wr_addr == ADDR_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         wr_addr      <= '0;
         rd_addr      <= '0;
         head_addr    <= '0;
         tail_addr    <= '0;
         cpu_run      <= 1'b0;
         cpu_pc_reset <= 1'b0;
         out_valid    <= 1'b0;
         overflow     <= 1'b0;
         timeout      <= 1'b0;
         wdog         <= '0;
      end else begin
         cpu_pc_reset <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wr_en) begin
                  head_addr <= '0;
                  wr_addr   <= ADDR_W'(1);
                  if (in_eop) begin
                     tail_addr    <= '0;
                     state        <= PROC;
                     cpu_pc_reset <= 1'b1;
                     wdog         <= '0;
                  end else begin
                     state <= RECV;
                  end
               end
            end
            RECV: begin
               if (wr_en) begin
                  if (wr_addr != ADDR_MAX)
                     wr_addr <= wr_addr + ADDR_W'(1);
                  if (last_word) begin
                     tail_addr    <= wr_addr;
                     state        <= PROC;
                     cpu_pc_reset <= 1'b1;
                     wdog         <= '0;
                     if (!in_eop)
                        overflow <= 1'b1;
                  end
               end
            end
            PROC: begin
               if (cpu_done || (wdog == WD_LAST)) begin
                  state     <= SEND;
                  cpu_run   <= 1'b0;
                  rd_addr   <= head_addr;
                  out_valid <= 1'b0;
                  if (!cpu_done)
                     timeout <= 1'b1;
               end else begin
                  wdog    <= wdog + 16'd1;
                  cpu_run <= 1'b1;
               end
            end
            SEND: begin
               // Each word gets a dead cycle to cover the buffer read latency.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  if (rd_addr == tail_addr) begin
                     state     <= IDLE;
                     wr_addr   <= '0;
                     head_addr <= '0;
                     tail_addr <= '0;
                     rd_addr   <= '0;
                  end else begin
                     rd_addr <= rd_addr + ADDR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
